// File: rtl/lift_pkg.sv
// lift_pkg: shared FSM encodings, lifting-step selectors and boundary mirroring for the 5/3 engines.
package lift_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PASS1 = 3'd2;
    localparam logic [2:0] S_PASS2 = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic PREDICT = 1'b0;
    localparam logic UPDATE  = 1'b1;
    localparam logic SUB = 1'b0;
    localparam logic ADD = 1'b1;
    // Whole-sample symmetric extension: x[-1] -> x[1], x[n] -> x[n-2].
    function automatic int mirror_idx(input int idx, input int n);
        return idx < 0 ? -idx : (idx >= n ? 2 * n - 2 - idx : idx);
    endfunction
endpackage

// File: rtl/lift53_row_engine_if.sv
// lift53_row_engine_if: valid/ready sample stream used for the row engine's input and output.
interface lift53_row_engine_if #(parameter int WIDTH = 16);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    modport master(output valid, output data, input ready);
    modport slave(input valid, input data, output ready);
endinterface

// File: rtl/lift53_step.sv
// lift53_step: one combinational 5/3 lifting step (predict or update, add or subtract).
module lift53_step
    import lift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] centre,
    input  logic signed [WIDTH-1:0] left,
    input  logic signed [WIDTH-1:0] right,
    input  logic                    kind,
    input  logic                    sign,
    output logic signed [WIDTH-1:0] result
);
    logic signed [WIDTH+1:0] l_x, r_x, bias, sum, d;
    always_comb begin
        l_x    = left;
        r_x    = right;
        bias   = kind == UPDATE ? (WIDTH+2)'(2) : '0;
        sum    = l_x + r_x + bias;
        d      = kind == PREDICT ? sum >>> 1 : sum >>> 2;
        result = sign == ADD ? centre + WIDTH'(d) : centre - WIDTH'(d);
    end
endmodule

// File: rtl/lift53_row_engine.sv
// lift53_row_engine: buffers a row, runs in-place 5/3 lifting passes (forward or inverse), streams it out.
module lift53_row_engine
    import lift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LW-1:0]       len,
    input  logic                inv,
    lift53_row_engine_if.slave  s_in,
    lift53_row_engine_if.master m_out,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int AW = $clog2(DEPTH);
    logic [2:0] state_q, state_d;
    logic [LW-1:0] len_q, len_d, cnt_q, cnt_d;
    logic inv_q, inv_d, out_valid_q, out_valid_d, done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic signed [WIDTH-1:0] step_res, wr_val;
    logic kind, sign, wr_en, len_ok, last_load, last_pass;
    int ci, li, ri, wr_idx;

    assign s_in.ready  = state_q == S_LOAD;
    assign m_out.valid = out_valid_q;
    assign m_out.data  = out_data_q;
    assign busy        = state_q != S_IDLE;
    assign done        = done_q;
    assign err         = err_q;

    // Forward: predict then update; inverse swaps the order. PASS1 always subtracts, PASS2 adds.
    always_comb begin
        kind      = ((state_q == S_PASS2) ^ inv_q) ? UPDATE : PREDICT;
        sign      = state_q == S_PASS2 ? ADD : SUB;
        ci        = 2 * int'(cnt_q) + int'(kind == PREDICT);
        li        = mirror_idx(ci - 1, int'(len_q));
        ri        = mirror_idx(ci + 1, int'(len_q));
        wr_en     = (state_q == S_LOAD && s_in.valid) || state_q == S_PASS1 || state_q == S_PASS2;
        wr_idx    = state_q == S_LOAD ? int'(cnt_q) : ci;
        wr_val    = state_q == S_LOAD ? s_in.data : step_res;
        len_ok    = !len[0] && len >= LW'(2) && len <= LW'(DEPTH);
        last_load = cnt_q == len_q - 1'b1;
        last_pass = cnt_q == (len_q >> 1) - 1'b1;
    end

    lift53_step #(.WIDTH(WIDTH)) u_step (
        .centre(mem_q[AW'(ci)]),
        .left  (mem_q[AW'(li)]),
        .right (mem_q[AW'(ri)]),
        .kind  (kind),
        .sign  (sign),
        .result(step_res)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        inv_d       = inv_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = len_ok ? S_LOAD : S_IDLE;
                len_d   = len_ok ? len : len_q;
                inv_d   = len_ok ? inv : inv_q;
                cnt_d   = '0;
                err_d   = !len_ok;
            end
            S_LOAD: if (s_in.valid) begin
                state_d = last_load ? S_PASS1 : S_LOAD;
                cnt_d   = last_load ? '0 : cnt_q + 1'b1;
            end
            S_PASS1: begin
                state_d = last_pass ? S_PASS2 : S_PASS1;
                cnt_d   = last_pass ? '0 : cnt_q + 1'b1;
            end
            // Element 0 may be written in the final PASS2 cycle (N = 2), so forward it.
            S_PASS2: begin
                state_d     = last_pass ? S_DRAIN : S_PASS2;
                cnt_d       = last_pass ? '0 : cnt_q + 1'b1;
                out_valid_d = last_pass;
                out_data_d  = last_pass ? (wr_idx == 0 ? step_res : mem_q[0]) : out_data_q;
            end
            S_DRAIN: if (m_out.ready) begin
                state_d     = last_load ? S_IDLE : S_DRAIN;
                out_valid_d = !last_load;
                done_d      = last_load;
                cnt_d       = cnt_q + 1'b1;
                out_data_d  = last_load ? out_data_q : mem_q[AW'(cnt_q + 1'b1)];
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[AW'(wr_idx)] <= wr_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            inv_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            inv_q       <= inv_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_lift53_row_engine.sv
// tb_lift53_row_engine: vector table, random rows against an arithmetic 5/3 model, and reset/error corners.
module tb_lift53_row_engine;
    localparam int W  = 16;
    localparam int D  = 64;
    localparam int LW = $clog2(D + 1);

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, inv = 1'b0;
    logic [LW-1:0] len = '0;
    logic busy, done, err;
    int n_cmp = 0, n_fail = 0;

    lift53_row_engine_if #(.WIDTH(W)) in_if();
    lift53_row_engine_if #(.WIDTH(W)) out_if();

    always #5 clk = ~clk;

    lift53_row_engine #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .inv(inv),
        .s_in(in_if), .m_out(out_if), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        int n; bit iv; int din[4]; int exp[4]; bit bp; bit gaps; bit poke;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrap(input int v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return int'(t);
    endfunction

    function automatic int fdiv(input int a, input int b);
        return a >= 0 ? a / b : -((-a + b - 1) / b);
    endfunction

    // Reference: lifting written directly from the predict/update equations with mirrored ends.
    function automatic void model(input int n, input bit iv, input int xi[D], output int y[D]);
        int x[D];
        x = xi;
        for (int p = 0; p < 2; p++) begin
            bit upd = (p == 1) ^ iv;
            int sg = (p == 1) ? 1 : -1;
            for (int i = upd ? 0 : 1; i < n; i += 2) begin
                int l = (i == 0) ? x[1] : x[i-1];
                int r = (i == n - 1) ? x[n-2] : x[i+1];
                x[i] = wrap(x[i] + sg * (upd ? fdiv(l + r + 2, 4) : fdiv(l + r, 2)));
            end
        end
        y = x;
    endfunction

    task automatic run_row(input int n, input bit iv, input int din[D], input bit gaps,
                           input bit bp, input bit poke, output int dout[D]);
        int k = 0, got = 0, first = -1, dc = 0, pd = 0, od = 0;
        bit seen = 0, stalled = 0, hs_in, hs_out;
        for (int cyc = 0; cyc < 6 * D + 50 && !seen; cyc++) begin
            start        = (cyc == 0) || (poke && cyc == 3);
            len          = LW'(cyc == 0 ? n : 2);
            inv          = (cyc == 0) ? iv : !iv;
            in_if.valid  = (k < n) && (!gaps || $urandom_range(0, 2) != 0);
            in_if.data   = W'(din[k < n ? k : 0]);
            out_if.ready = !bp || (dc % 4 == 0) || (dc % 4 == 3);
            hs_in  = in_if.ready && in_if.valid;
            hs_out = out_if.valid && out_if.ready;
            od     = int'($signed(out_if.data));
            if (out_if.valid) begin
                if (first < 0) first = cyc;
                if (stalled) chk("hold_data", od, pd);
                dc++;
            end
            if (done) begin
                chk("busy_at_done", int'(busy), 0);
                seen = 1;
            end
            stalled = out_if.valid && !out_if.ready;
            pd = od;
            @(posedge clk); #1;
            if (hs_in) k++;
            if (hs_out && got < D) begin
                dout[got] = od;
                got++;
            end
        end
        start = 1'b0;
        in_if.valid = 1'b0;
        out_if.ready = 1'b1;
        chk("done_seen", int'(seen), 1);
        chk("out_count", got, n);
        if (!gaps) chk("first_out_cycle", first, 2 * n + 1);
        chk("done_pulse_width", int'(done), 0);
        chk("idle_after", int'(busy), 0);
    endtask

    initial begin
        int din[D], y[D], z[D], e[D];
        int bad_len[3] = '{3, 0, D + 2};
        tbl[0] = '{4, 1'b0, '{215, 217, 216, 218}, '{216, 2, 217, 2}, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{4, 1'b1, '{216, 2, 217, 2}, '{215, 217, 216, 218}, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{2, 1'b0, '{10, 20, 0, 0}, '{15, 10, 0, 0}, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{2, 1'b0, '{0, -5, 0, 0}, '{-2, -5, 0, 0}, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{4, 1'b0, '{215, 217, 216, 218}, '{216, 2, 217, 2}, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{4, 1'b0, '{215, 217, 216, 218}, '{216, 2, 217, 2}, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{4, 1'b0, '{215, 217, 216, 218}, '{216, 2, 217, 2}, 1'b0, 1'b0, 1'b1};
        in_if.valid = 1'b0;
        in_if.data = '0;
        out_if.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_in_ready", int'(in_if.ready), 0);
        chk("rst_out_valid", int'(out_if.valid), 0);
        chk("rst_out_data", int'(out_if.data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[t]) begin
            din = '{default: 0};
            for (int i = 0; i < 4; i++) din[i] = tbl[t].din[i];
            run_row(tbl[t].n, tbl[t].iv, din, tbl[t].gaps, tbl[t].bp, tbl[t].poke, y);
            for (int i = 0; i < tbl[t].n; i++) chk($sformatf("vec%0d[%0d]", t, i), y[i], tbl[t].exp[i]);
        end

        foreach (bad_len[b]) begin
            start = 1'b1;
            len = LW'(bad_len[b]);
            @(posedge clk); #1;
            start = 1'b0;
            chk($sformatf("err_len%0d", bad_len[b]), int'(err), 1);
            chk($sformatf("busy_len%0d", bad_len[b]), int'(busy), 0);
            chk($sformatf("in_ready_len%0d", bad_len[b]), int'(in_if.ready), 0);
            @(posedge clk); #1;
            chk($sformatf("err_clear_len%0d", bad_len[b]), int'(err), 0);
        end

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < D; i++) din[i] = int'($urandom_range(0, 65535)) - 32768;
            model(D, 1'b0, din, e);
            run_row(D, 1'b0, din, 1'b0, 1'b0, 1'b0, y);
            for (int i = 0; i < D; i++) chk($sformatf("rnd_fwd%0d[%0d]", t, i), y[i], e[i]);
            run_row(D, 1'b1, y, 1'b0, 1'b0, 1'b0, z);
            for (int i = 0; i < D; i++) chk($sformatf("rnd_rt%0d[%0d]", t, i), z[i], din[i]);
        end

        for (int t = 0; t < 4; t++) begin
            int n = 2 * int'($urandom_range(1, D / 2));
            bit iv = 1'($urandom_range(0, 1));
            for (int i = 0; i < D; i++) din[i] = int'($urandom_range(0, 65535)) - 32768;
            model(n, iv, din, e);
            run_row(n, iv, din, 1'b1, 1'b1, 1'b0, y);
            for (int i = 0; i < n; i++) chk($sformatf("rnd_n%0d_inv%0d[%0d]", n, iv, i), y[i], e[i]);
        end

        for (int i = 0; i < D; i++) din[i] = int'($urandom_range(0, 65535)) - 32768;
        start = 1'b1;
        len = LW'(D);
        inv = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        in_if.valid = 1'b1;
        for (int i = 0; i < D; i++) begin
            in_if.data = W'(din[i]);
            @(posedge clk); #1;
        end
        in_if.valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_pre_reset", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_out_valid", int'(out_if.valid), 0);
        chk("arst_out_data", int'(out_if.data), 0);
        chk("arst_in_ready", int'(in_if.ready), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_err", int'(err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        din = '{default: 0};
        for (int i = 0; i < 4; i++) din[i] = tbl[0].din[i];
        run_row(4, 1'b0, din, 1'b0, 1'b0, 1'b0, y);
        for (int i = 0; i < 4; i++) chk($sformatf("post_reset[%0d]", i), y[i], tbl[0].exp[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lift53_row_engine.md
Name: lift53_row_engine

Overview:
- Parametrised successor to the single-sample lifting `jpeg` step: a full-row 5/3 (LeGall) integer wavelet engine.
- Accepts a row of up to DEPTH samples over a valid/ready stream into an internal buffer, runs predict then update passes in place (forward) or the reverse (inverse), then streams the interleaved result out.
- Sits between the sample RAM reader and the column/row transpose stage of the JPEG 2000 path.

Parameters:
WIDTH, 16, sample width in bits (signed two's complement)
DEPTH, 64, maximum row length; power of two, >= 2
LW, $clog2(DEPTH+1), width of the length field (derived; not to be overridden)

Ports:
clk        in   1      clock
rst_n      in   1      asynchronous active-low reset
start      in   1      pulse in IDLE: latch len and inv, begin LOAD
len        in   LW     row length N; legal only if even and 2..DEPTH
inv        in   1      0 = forward DWT, 1 = inverse DWT
in_valid   in   1      input sample valid
in_ready   out  1      high only in LOAD
in_data    in   WIDTH  input sample, natural index order
out_valid  out  1      output sample valid
out_ready  in   1      downstream accept
out_data   out  WIDTH  output sample, index order (even = low band, odd = high band)
busy       out  1      high in every state except IDLE
done       out  1      one-cycle pulse after the last output handshake
err        out  1      one-cycle pulse when start is given with an illegal len

Behaviour:
- Reset state: IDLE. All outputs are 0. Buffer contents are undefined. Reset asserted mid-operation aborts immediately to IDLE.
- States: IDLE -> LOAD -> PASS1 -> PASS2 -> DRAIN -> IDLE.
- IDLE:
  - start with legal len: latch N and inv, go to LOAD.
  - start with illegal len (odd, 0, or > DEPTH): pulse err next cycle, stay IDLE.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready = 1; each in_valid & in_ready beat writes buf[k], k = 0..N-1.
  - After beat N-1, go to PASS1.
- PASS1 / PASS2: one element per cycle, N/2 cycles each; no handshake. Operand reads are combinational from the register-file buffer.
  - Predict, odd i = 1,3,..,N-1: x[i] -/+ floor((x[i-1]+x[i+1])/2).
  - Update, even i = 0,2,..,N-2: x[i] +/- floor((x[i-1]+x[i+1]+2)/4).
  - Forward: PASS1 = predict (subtract), PASS2 = update (add).
  - Inverse: PASS1 = update (subtract), PASS2 = predict (add).
- Symmetric boundary extension: x[-1] := x[1]; x[N] := x[N-2]. N = 2 therefore uses x[0] on both sides for predict and x[1] on both sides for update.
- Arithmetic:
  - Neighbour sum is formed in WIDTH+2 bits, then arithmetic right shift (floor for negatives).
  - Result is truncated to WIDTH (wrap, no saturation).
  - Forward followed by inverse is bit-exact for any input.
- DRAIN:
  - Presents buf[0..N-1] in order.
  - out_data is registered and held stable while out_valid & !out_ready.
  - First out_valid arrives in the cycle after the last PASS2 write.
  - After the handshake of element N-1: out_valid = 0, done pulses for 1 cycle, return to IDLE.
- Latency: start-to-first-output = N (load, at full rate) + N (passes) + 1 cycles; throughput is one row per 2N+1+N cycles with no backpressure.

Decomposition:
- Package lift_pkg:
  - state enum (IDLE, LOAD, PASS1, PASS2, DRAIN)
  - pass-kind constants (PREDICT, UPDATE)
  - sign-select constants (SUB, ADD)
  - function computing the neighbour index with mirror extension
- Sub-module lift53_step: purely combinational.
  - Inputs: centre, left, right, kind, sign.
  - Output: WIDTH result.
  - Generalises the single-sample step and is reused by the column engine.

Test Plan:
1. Forward, N=4, in [215,217,216,218] -> out [216,2,217,2]; done pulses once; busy falls in the same cycle as done.
2. Inverse, N=4, in [216,2,217,2] -> out [215,217,216,218]. Then random N=DEPTH rows, forward then inverse -> bit-exact round trip.
3. N=2 edge: forward [10,20] -> [15,10]. Negative floor: forward [0,-5] -> [-2,-5].
4. Backpressure: out_ready toggled 1,0,0,1 during scenario 1 -> out_data stable while stalled, no sample lost or duplicated. Also in_valid gaps in LOAD -> same result.
5. Illegal len: start with len = 3, 0, DEPTH+2 -> err pulse, busy stays 0, in_ready stays 0. start while busy -> ignored, row unaffected.
6. rst_n dropped in PASS1 -> all outputs 0 asynchronously, state IDLE. A new start then yields the correct result for scenario 1.
